wb_mux_n: RTL

- Parametrised N-way Wishbone classic interconnect. Successor to the fixed two-peripheral mux.
- Sits between the Caravel management Wishbone master and up to NUM_SLAVES user peripherals (wfg_top, wb_memory, future blocks).
- Adds three features the two-way mux lacks:
  - Address-window decode against a configurable base.
  - An unmapped-address error response.
  - A per-transaction timeout that completes hung cycles with an error word.

---
 rtl/wb_mux_pkg.sv | 21 ++
 rtl/wb_mux_decode.sv | 27 ++
 rtl/wb_mux_n.sv | 138 +++++++++++++
 3 files changed

// File: rtl/wb_mux_pkg.sv
// wb_mux_pkg: shared types and constants for the N-way Wishbone interconnect.
//   state_t         - interconnect FSM states
//   DEF_BASE_ADDR   - default base of the user address window
//   DEF_ERR_DATA    - default read word returned on error/timeout
//   slice_lsb()     - LSB position of slice idx in a flattened per-slave bus
package wb_mux_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,   // waiting for a request, decoding the address
      ST_FWD  = 2'd1,   // request forwarded to the latched slave
      ST_ERR  = 2'd2    // one-cycle error completion
   } state_t;

   localparam logic [31:0] DEF_BASE_ADDR = 32'h3000_0000;
   localparam logic [31:0] DEF_ERR_DATA  = 32'hDEAD_BEEF;

   function automatic int slice_lsb(input int idx, input int width);
      return idx * width;
   endfunction

endpackage

// File: rtl/wb_mux_decode.sv
// wb_mux_decode: combinational address-window decode.
//   adr_hi  in   address bits [ADDR_W-1:IDX_LSB]; bits below the index field
//                never take part in the decode, so they are not brought in
//   idx     out  slave index field
//   mapped  out  address is inside the window and idx names an existing slave
module wb_mux_decode
   import wb_mux_pkg::*;
#(
   parameter int                NUM_SLAVES = 4,
   parameter int                ADDR_W     = 32,
   parameter int                IDX_LSB    = 16,
   parameter int                IDX_W      = 2,
   parameter logic [ADDR_W-1:0] BASE_ADDR  = ADDR_W'(DEF_BASE_ADDR)
) (
   input  logic [ADDR_W-1:IDX_LSB] adr_hi,
   output logic [IDX_W-1:0]        idx,
   output logic                    mapped
);

   logic hit;

   assign hit    = adr_hi[ADDR_W-1:IDX_LSB+IDX_W] == BASE_ADDR[ADDR_W-1:IDX_LSB+IDX_W];
   assign idx    = adr_hi[IDX_LSB +: IDX_W];
   // Extra MSB so NUM_SLAVES == 2**IDX_W still compares correctly.
   assign mapped = hit && ({1'b0, idx} < (IDX_W+1)'(NUM_SLAVES));

endmodule

// File: rtl/wb_mux_n.sv
// wb_mux_n: N-way Wishbone classic interconnect with window decode,
// unmapped-address error response and per-transaction timeout.
//   io_wbs_clk/io_wbs_rst      clock, synchronous active-high reset
//   io_wbs_adr..io_wbs_ack     master-side Wishbone port
//   io_wbs_*_s                 flattened per-slave ports, slice i = slave i;
//                              adr/datwr/we/sel broadcast, stb/cyc gated
//   err_o                      one-cycle pulse per error completion
//   err_cnt_o                  saturating error completion count
module wb_mux_n
   import wb_mux_pkg::*;
#(
   parameter int                NUM_SLAVES     = 4,
   parameter int                DATA_W         = 32,
   parameter int                ADDR_W         = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR      = ADDR_W'(DEF_BASE_ADDR),
   parameter int                IDX_LSB        = 16,
   parameter int                IDX_W          = 2,
   parameter int                TIMEOUT_CYCLES = 255,
   parameter logic [DATA_W-1:0] ERR_DATA       = DATA_W'(DEF_ERR_DATA)
) (
   input  logic                             io_wbs_clk,
   input  logic                             io_wbs_rst,
   input  logic [ADDR_W-1:0]                io_wbs_adr,
   input  logic [DATA_W-1:0]                io_wbs_datwr,
   output logic [DATA_W-1:0]                io_wbs_datrd,
   input  logic                             io_wbs_we,
   input  logic [DATA_W/8-1:0]              io_wbs_sel,
   input  logic                             io_wbs_stb,
   input  logic                             io_wbs_cyc,
   output logic                             io_wbs_ack,
   output logic [NUM_SLAVES*ADDR_W-1:0]     io_wbs_adr_s,
   output logic [NUM_SLAVES*DATA_W-1:0]     io_wbs_datwr_s,
   input  logic [NUM_SLAVES*DATA_W-1:0]     io_wbs_datrd_s,
   output logic [NUM_SLAVES-1:0]            io_wbs_we_s,
   output logic [NUM_SLAVES*(DATA_W/8)-1:0] io_wbs_sel_s,
   output logic [NUM_SLAVES-1:0]            io_wbs_stb_s,
   output logic [NUM_SLAVES-1:0]            io_wbs_cyc_s,
   input  logic [NUM_SLAVES-1:0]            io_wbs_ack_s,
   output logic                             err_o,
   output logic [7:0]                       err_cnt_o
);

   localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  idx_q, dec_idx;
   logic              dec_mapped;
   logic [15:0]       timer_q;
   logic [7:0]        err_cnt_q;
   logic              req;
   logic              sel_ack;
   logic [DATA_W-1:0] sel_dat;

   assign req = io_wbs_cyc & io_wbs_stb;

   wb_mux_decode #(
      .NUM_SLAVES (NUM_SLAVES),
      .ADDR_W     (ADDR_W),
      .IDX_LSB    (IDX_LSB),
      .IDX_W      (IDX_W),
      .BASE_ADDR  (BASE_ADDR)
   ) u_decode (
      .adr_hi (io_wbs_adr[ADDR_W-1:IDX_LSB]),
      .idx    (dec_idx),
      .mapped (dec_mapped)
   );

   // Address, data, we and sel need no gating: a slave ignores them without stb.
   assign io_wbs_adr_s   = {NUM_SLAVES{io_wbs_adr}};
   assign io_wbs_datwr_s = {NUM_SLAVES{io_wbs_datwr}};
   assign io_wbs_we_s    = {NUM_SLAVES{io_wbs_we}};
   assign io_wbs_sel_s   = {NUM_SLAVES{io_wbs_sel}};
   assign err_cnt_o      = err_cnt_q;

   // Response of the latched slave.
   always_comb begin
      sel_ack = 1'b0;
      sel_dat = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (idx_q == IDX_W'(i)) begin
            sel_ack = io_wbs_ack_s[i];
            sel_dat = io_wbs_datrd_s[slice_lsb(i, DATA_W) +: DATA_W];
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      io_wbs_stb_s = '0;
      io_wbs_cyc_s = '0;
      io_wbs_ack   = 1'b0;
      io_wbs_datrd = '0;
      err_o        = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req) state_d = dec_mapped ? ST_FWD : ST_ERR;
         end
         ST_FWD: begin
            for (int i = 0; i < NUM_SLAVES; i++) begin
               if (idx_q == IDX_W'(i)) begin
                  io_wbs_stb_s[i] = io_wbs_stb;
                  io_wbs_cyc_s[i] = io_wbs_cyc;
               end
            end
            io_wbs_ack   = sel_ack;
            io_wbs_datrd = sel_dat;
            // Ack is checked first so an ack on the last timer cycle wins.
            if (sel_ack || !io_wbs_cyc) state_d = ST_IDLE;
            else if (timer_q == TO_LAST) state_d = ST_ERR;
         end
         ST_ERR: begin
            io_wbs_ack   = 1'b1;
            io_wbs_datrd = ERR_DATA;
            err_o        = 1'b1;
            state_d      = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge io_wbs_clk) begin
      if (io_wbs_rst) begin
         state_q   <= ST_IDLE;
         idx_q     <= '0;
         timer_q   <= '0;
         err_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == ST_IDLE && req && dec_mapped) begin
            idx_q   <= dec_idx;
            timer_q <= '0;
         end
         if (state_q == ST_FWD && !sel_ack) timer_q <= timer_q + 16'd1;
         if (state_q == ST_ERR && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
      end
   end

endmodule
